// File: rtl/fifo_2clk_pkg.sv
// Shared defaults and helpers for the single-clock FIFO and its storage array.
package fifo_2clk_pkg;

    localparam int FIFO_DEPTH  = 8;
    localparam int FIFO_DATA_W = 8;

    // Number of address bits needed to index v entries (v >= 2).
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < v) r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/fifo_2clk_mem.sv
// FIFO storage: register array with a synchronous write port and an asynchronous read port.
module fifo_mem
    import fifo_2clk_pkg::*;
#(
    parameter int DEPTH  = FIFO_DEPTH,
    parameter int DATA_W = FIFO_DATA_W,
    parameter int AW     = clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Contents are deliberately left unreset; stale words are unreachable once pointers clear.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fifo_2clk.sv
// Single-clock FIFO control: pointers, occupancy count, status flags and registered read data.
module fifo_2clk
    import fifo_2clk_pkg::*;
#(
    parameter int FIFOD = FIFO_DEPTH,
    parameter int DATAD = FIFO_DATA_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr,
    input  logic             rd,
    input  logic [DATAD-1:0] in,
    output logic [DATAD-1:0] out,
    output logic             full,
    output logic             empty
);

    localparam int AW = clog2(FIFOD);
    localparam int CW = AW + 1;

    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [DATAD-1:0] out_q, out_d;
    logic [DATAD-1:0] mem_rdata;
    logic             wr_acc;
    logic             rd_acc;

    assign full   = (cnt_q == CW'(FIFOD));
    assign empty  = (cnt_q == '0);
    assign wr_acc = wr && !full;
    assign rd_acc = rd && !empty;
    assign out    = out_q;

    fifo_mem #(
        .DEPTH  (FIFOD),
        .DATA_W (DATAD),
        .AW     (AW)
    ) u_mem (
        .clk     (clk),
        .we_i    (wr_acc),
        .waddr_i (wptr_q),
        .wdata_i (in),
        .raddr_i (rptr_q),
        .rdata_o (mem_rdata)
    );

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        out_d  = out_q;
        if (wr_acc) begin
            wptr_d = wptr_q + AW'(1);
        end
        if (rd_acc) begin
            rptr_d = rptr_q + AW'(1);
            out_d  = mem_rdata;
        end
        // A simultaneous accepted read and write leaves the occupancy unchanged.
        case ({wr_acc, rd_acc})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            out_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
            out_q  <= out_d;
        end
    end

endmodule

// File: tb/tb_fifo_2clk.sv
// Directed and randomized bench for fifo_2clk against a queue-based reference model.
module tb_fifo_2clk;

    localparam int FIFOD = 8;
    localparam int DATAD = 8;

    logic             clk;
    logic             rst;
    logic             wr;
    logic             rd;
    logic [DATAD-1:0] din;
    logic [DATAD-1:0] dout;
    logic             full;
    logic             empty;

    int total;
    int bad;

    logic [DATAD-1:0] model_q [$];
    logic [DATAD-1:0] model_out;

    fifo_2clk #(
        .FIFOD (FIFOD),
        .DATAD (DATAD)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .wr    (wr),
        .rd    (rd),
        .in    (din),
        .out   (dout),
        .full  (full),
        .empty (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DATAD-1:0] obs, input logic [DATAD-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".out"}, dout, model_out);
        chk({tag, ".full"}, {7'd0, full}, {7'd0, model_q.size() == FIFOD});
        chk({tag, ".empty"}, {7'd0, empty}, {7'd0, model_q.size() == 0});
    endtask

    // Called at a negedge; applies inputs for one rising edge, then checks 1 ns after it.
    task automatic cycle(input logic w, input logic r, input logic [DATAD-1:0] d, input string tag);
        logic wacc;
        logic racc;
        wr  = w;
        rd  = r;
        din = d;
        wacc = w && (model_q.size() < FIFOD);
        racc = r && (model_q.size() > 0);
        @(posedge clk);
        if (racc) model_out = model_q.pop_front();
        if (wacc) model_q.push_back(d);
        #1;
        chk_model(tag);
        @(negedge clk);
    endtask

    initial begin
        logic [DATAD-1:0] five [5];
        five[0] = 8'h24; five[1] = 8'h81; five[2] = 8'h09; five[3] = 8'h63; five[4] = 8'h0D;
        total = 0;
        bad = 0;
        model_out = '0;
        wr = 1'b0;
        rd = 1'b0;
        din = '0;

        // Reset held for 20 ns.
        rst = 1'b0;
        #20;
        chk("rst.out", dout, 8'h00);
        chk("rst.empty", {7'd0, empty}, 8'd1);
        chk("rst.full", {7'd0, full}, 8'd0);
        @(negedge clk);
        rst = 1'b1;
        cycle(1'b0, 1'b0, 8'h00, "idle0");
        cycle(1'b0, 1'b0, 8'h00, "idle1");

        // Five single writes then five single reads.
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 1'b0, five[i], "wr5");
            chk("wr5.empty_lo", {7'd0, empty}, 8'd0);
            cycle(1'b0, 1'b0, 8'hFF, "wr5.gap");
        end
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 1'b1, 8'h00, "rd5");
            chk("rd5.data", dout, five[i]);
        end
        chk("rd5.empty", {7'd0, empty}, 8'd1);

        // Overfill: last two writes dropped.
        for (int i = 1; i <= 10; i++) begin
            cycle(1'b1, 1'b0, 8'(i), "fill");
            if (i == 8) chk("fill.full8", {7'd0, full}, 8'd1);
        end
        // Over-drain: last two reads leave out at 0x08.
        for (int i = 1; i <= 10; i++) begin
            cycle(1'b0, 1'b1, 8'h00, "drain");
            chk("drain.data", dout, 8'(i > 8 ? 8 : i));
            if (i == 8) chk("drain.empty8", {7'd0, empty}, 8'd1);
        end

        // Concurrent read/write with three words stored; pointers wrap.
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 8'(8'h30 + i), "pre3");
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, 1'b1, 8'(8'h40 + i), "both");
            chk("both.data", dout, (i < 3) ? 8'(8'h30 + i) : 8'(8'h40 + i - 3));
        end
        chk("both.cnt3", 8'(model_q.size()), 8'd3);

        // Asynchronous reset between clock edges.
        wr = 1'b0;
        rd = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        chk("arst.out", dout, 8'h00);
        chk("arst.empty", {7'd0, empty}, 8'd1);
        chk("arst.full", {7'd0, full}, 8'd0);
        model_q.delete();
        model_out = '0;
        @(negedge clk);
        rst = 1'b1;
        cycle(1'b1, 1'b0, 8'hA5, "post.wr");
        cycle(1'b0, 1'b1, 8'h00, "post.rd");
        chk("post.data", dout, 8'hA5);

        // Randomized traffic with varying read/write bias.
        for (int i = 0; i < 400; i++) begin
            int bias;
            bias = (i / 100) % 2 == 0 ? 70 : 30;
            cycle($urandom_range(99) < bias, $urandom_range(99) >= bias - 5,
                  8'($urandom), "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
